// File: rtl/sram_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_fifo_pkg
//  Description : Shared types and helpers for the SRAM-backed stereo-sample
//                FIFO controller. Holds the controller state encoding, the
//                byte/sample widths, and the helper that forms a byte address
//                from a sample pointer and a high-byte select.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_fifo_pkg;

    localparam int BYTE_W   = 8;
    localparam int SAMPLE_W = 16;
    // Widest SRAM address the byte_addr helper can form.
    localparam int MAX_AW   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_LO  = 3'd1,
        WR_HI  = 3'd2,
        RD_LO  = 3'd3,
        RD_HI  = 3'd4,
        RD_CAP = 3'd5
    } state_t;

    // Sample p lives at byte addresses 2p (low byte) and 2p+1 (high byte).
    function automatic logic [MAX_AW-1:0] byte_addr(input logic [MAX_AW-2:0] ptr,
                                                    input logic              hi_sel);
        return {ptr, hi_sel};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_sample_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_sample_fifo_ctrl
//  Description : Elastic/delay buffer for the audio path. Presents a 16-bit
//                sample FIFO with valid/ready on both sides and stores each
//                sample as two bytes in a 256x8 single-port SRAM macro.
//                Optional feature macro: SRAM_SAMPLE_FIFO_HWM_EN adds the hwm
//                output (maximum count seen since reset).
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, reset            : clock (also the SRAM CE), async active-high reset
//    in_valid/ready/data   : sample input handshake
//    out_valid/ready/data  : sample output handshake (one-sample holding reg)
//    count                 : samples currently held in the SRAM (0..DEPTH)
//    sram_a/i/o            : SRAM address, write data, read data
//    sram_csb/web/oeb      : SRAM chip select / write / output enable (low)
//    hwm                   : high-water mark (only with the feature macro)
// ============================================================================
module sram_sample_fifo_ctrl #(
    parameter int SRAM_AW  = 8,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_data,
    output logic [SRAM_AW-1:0]  count,
    output logic [SRAM_AW-1:0]  sram_a,
    output logic [7:0]          sram_i,
    input  logic [7:0]          sram_o,
    output logic                sram_csb,
    output logic                sram_web,
    output logic                sram_oeb
`ifdef SRAM_SAMPLE_FIFO_HWM_EN
    ,
    output logic [SRAM_AW-1:0]  hwm
`endif
);
    import sram_fifo_pkg::*;

    localparam int                 c_ptr_w     = SRAM_AW - 1;
    localparam logic [SRAM_AW-1:0] c_depth     = {1'b1, {(SRAM_AW-1){1'b0}}};
    localparam logic [SRAM_AW-1:0] c_count_one = {{(SRAM_AW-1){1'b0}}, 1'b1};
    localparam logic [c_ptr_w-1:0] c_ptr_one   = {{(c_ptr_w-1){1'b0}}, 1'b1};

    generate
        if (SAMPLE_W != 2 * BYTE_W) begin : g_bad_sample_w
            $error("sram_sample_fifo_ctrl: SAMPLE_W must equal two SRAM bytes");
        end
    endgenerate

    state_t                r_state;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [SRAM_AW-1:0]    r_count;
    logic [SAMPLE_W-1:0]   r_wr_data;
    logic [BYTE_W-1:0]     r_rd_lo;
    logic                  r_out_valid;
    logic [SAMPLE_W-1:0]   r_out_data;
    logic [SRAM_AW-1:0]    r_sram_a;
    logic [7:0]            r_sram_i;
    logic                  r_sram_csb;
    logic                  r_sram_web;
    logic                  r_sram_oeb;

    logic w_full;
    logic w_rd_start;
    logic w_wr_start;

    assign w_full     = (r_count == c_depth);
    // Refilling the empty output register takes priority over accepting input.
    assign w_rd_start = (r_state == IDLE) && !r_out_valid && (r_count != '0);
    assign in_ready   = (r_state == IDLE) && !w_rd_start && !w_full;
    assign w_wr_start = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_data   <= '0;
            r_rd_lo     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sram_a    <= '0;
            r_sram_i    <= '0;
            r_sram_csb  <= 1'b1;
            r_sram_web  <= 1'b1;
            r_sram_oeb  <= 1'b1;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            // SRAM command registers are loaded with the command for the state
            // being entered, so the macro samples it at the edge ending that state.
            case (r_state)
                IDLE: begin
                    if (w_rd_start) begin
                        r_state    <= RD_LO;
                        r_count    <= r_count - c_count_one;
                        r_sram_csb <= 1'b0;
                        r_sram_oeb <= 1'b0;
                        r_sram_web <= 1'b1;
                        r_sram_a   <= SRAM_AW'(byte_addr((MAX_AW-1)'(r_rd_ptr), 1'b0));
                    end else if (w_wr_start) begin
                        r_state    <= WR_LO;
                        r_wr_data  <= in_data;
                        r_sram_csb <= 1'b0;
                        r_sram_web <= 1'b0;
                        r_sram_oeb <= 1'b1;
                        r_sram_a   <= SRAM_AW'(byte_addr((MAX_AW-1)'(r_wr_ptr), 1'b0));
                        r_sram_i   <= in_data[BYTE_W-1:0];
                    end
                end
                WR_LO: begin
                    r_state  <= WR_HI;
                    r_sram_a <= SRAM_AW'(byte_addr((MAX_AW-1)'(r_wr_ptr), 1'b1));
                    r_sram_i <= r_wr_data[2*BYTE_W-1:BYTE_W];
                end
                WR_HI: begin
                    // Sample only becomes visible once both bytes are committed.
                    r_state    <= IDLE;
                    r_sram_csb <= 1'b1;
                    r_sram_web <= 1'b1;
                    r_wr_ptr   <= r_wr_ptr + c_ptr_one;
                    r_count    <= r_count + c_count_one;
                end
                RD_LO: begin
                    r_state  <= RD_HI;
                    r_sram_a <= SRAM_AW'(byte_addr((MAX_AW-1)'(r_rd_ptr), 1'b1));
                end
                RD_HI: begin
                    // Low byte from the RD_LO access is on sram_o now.
                    r_state    <= RD_CAP;
                    r_rd_lo    <= sram_o;
                    r_sram_csb <= 1'b1;
                    r_sram_oeb <= 1'b1;
                end
                RD_CAP: begin
                    r_state     <= IDLE;
                    r_out_data  <= {sram_o, r_rd_lo};
                    r_out_valid <= 1'b1;
                    r_rd_ptr    <= r_rd_ptr + c_ptr_one;
                end
                default: begin
                    r_state    <= IDLE;
                    r_sram_csb <= 1'b1;
                    r_sram_web <= 1'b1;
                    r_sram_oeb <= 1'b1;
                end
            endcase
        end
    end

`ifdef SRAM_SAMPLE_FIFO_HWM_EN
    logic [SRAM_AW-1:0] r_hwm;

    // Tracks the registered count, so it trails a rise in count by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hwm <= '0;
        end else if (r_count > r_hwm) begin
            r_hwm <= r_count;
        end
    end

    assign hwm = r_hwm;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign count     = r_count;
    assign sram_a    = r_sram_a;
    assign sram_i    = r_sram_i;
    assign sram_csb  = r_sram_csb;
    assign sram_web  = r_sram_web;
    assign sram_oeb  = r_sram_oeb;

endmodule
`default_nettype wire

// File: tb/tb_sram_sample_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_sample_fifo_ctrl
//  Description : Directed self-checking bench for sram_sample_fifo_ctrl with a
//                behavioural 256x8 single-port SRAM (registered read data).
//                Define SRAM_SAMPLE_FIFO_HWM_EN to exercise the hwm output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_sample_fifo_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  count;
    logic [7:0]  sram_a;
    logic [7:0]  sram_i;
    logic [7:0]  sram_o;
    logic        sram_csb;
    logic        sram_web;
    logic        sram_oeb;
`ifdef SRAM_SAMPLE_FIFO_HWM_EN
    logic [7:0]  hwm;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    sram_sample_fifo_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .sram_a    (sram_a),
        .sram_i    (sram_i),
        .sram_o    (sram_o),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_oeb  (sram_oeb)
`ifdef SRAM_SAMPLE_FIFO_HWM_EN
        ,
        .hwm       (hwm)
`endif
    );

    // SRAM1RW256x8 model: command sampled at posedge, read data valid next cycle.
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) mem[sram_a] <= sram_i;
            if (!sram_oeb) sram_o <= mem[sram_a];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n_tests++;
        assert (!(sram_web === 1'b0 && sram_oeb === 1'b0)) else begin
            n_fail++;
            $error("FAIL web_oeb_excl observed web=%b oeb=%b expected not both 0", sram_web, sram_oeb);
        end
    endtask

    task automatic push(input logic [15:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 40 && !done; k++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("push_accept", 32'(done), 32'd1);
    endtask

    task automatic pop(input logic [15:0] exp);
        bit done;
        done      = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            if (out_valid) begin
                done = 1'b1;
                check("pop_data", 32'(out_data), 32'(exp));
            end
            tick();
        end
        out_ready = 1'b0;
        check("pop_valid", 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  wr_i;
        int  rd_i;
        bit  w_acc;
        bit  r_acc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Values while reset is held
        check("rst_csb", 32'(sram_csb), 32'd1);
        check("rst_web", 32'(sram_web), 32'd1);
        check("rst_oeb", 32'(sram_oeb), 32'd1);
        check("rst_a", 32'(sram_a), 32'd0);
        check("rst_i", 32'(sram_i), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        reset = 1'b0;

        // Idle with empty FIFO: no SRAM access
        repeat (10) tick();
        check("idle_csb", 32'(sram_csb), 32'd1);
        check("idle_web", 32'(sram_web), 32'd1);
        check("idle_oeb", 32'(sram_oeb), 32'd1);
        check("idle_count", 32'(count), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Single write 0xA55A, cycle-by-cycle
        in_valid = 1'b1;
        in_data  = 16'hA55A;
        tick();
        in_valid = 1'b0;
        check("wrlo_csb", 32'(sram_csb), 32'd0);
        check("wrlo_web", 32'(sram_web), 32'd0);
        check("wrlo_oeb", 32'(sram_oeb), 32'd1);
        check("wrlo_a", 32'(sram_a), 32'd0);
        check("wrlo_i", 32'(sram_i), 32'h5A);
        check("wrlo_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("wrhi_a", 32'(sram_a), 32'd1);
        check("wrhi_i", 32'(sram_i), 32'hA5);
        check("wrhi_count", 32'(count), 32'd0);
        tick();
        check("wr_done_count", 32'(count), 32'd1);
        check("wr_done_csb", 32'(sram_csb), 32'd1);
        check("mem0", 32'(mem[0]), 32'h5A);
        check("mem1", 32'(mem[1]), 32'hA5);
        check("rd_prio_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("rdlo_count", 32'(count), 32'd0);
        check("rdlo_csb", 32'(sram_csb), 32'd0);
        check("rdlo_oeb", 32'(sram_oeb), 32'd0);
        check("rdlo_web", 32'(sram_web), 32'd1);
        check("rdlo_a", 32'(sram_a), 32'd0);
        tick();
        check("rdhi_a", 32'(sram_a), 32'd1);
        tick();
        check("rdcap_csb", 32'(sram_csb), 32'd1);
        check("rdcap_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("rd_out_valid", 32'(out_valid), 32'd1);
        check("rd_out_data", 32'(out_data), 32'hA55A);
        check("rd_count", 32'(count), 32'd0);
        check("rd_held_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rd_clear_valid", 32'(out_valid), 32'd0);

        // Fill: one held in the output register, then 128 in SRAM
        push(16'hFFFF);
        for (int i = 0; i < 128; i++) push(16'(i));
        repeat (4) tick();
        check("full_count", 32'(count), 32'd128);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_out_data", 32'(out_data), 32'hFFFF);
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        repeat (3) tick();
        in_valid = 1'b0;
        check("full_hold_count", 32'(count), 32'd128);
        pop(16'hFFFF);
        for (int i = 0; i < 128; i++) pop(16'(i));
        repeat (5) tick();
        check("drain_count", 32'(count), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // Streaming: 300 samples, both sides always willing
        wr_i      = 0;
        rd_i      = 0;
        in_valid  = 1'b1;
        in_data   = 16'h8000;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6000 && rd_i < 300; cyc++) begin
            w_acc = in_valid && in_ready;
            r_acc = out_valid && out_ready;
            if (r_acc) begin
                check("stream_data", 32'(out_data), 32'h8000 + 32'(rd_i));
                rd_i++;
            end
            tick();
            if (w_acc) begin
                wr_i++;
                in_data = 16'(32'h8000 + 32'(wr_i));
                if (wr_i == 300) in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        check("stream_read_total", 32'(rd_i), 32'd300);
        check("stream_write_total", 32'(wr_i), 32'd300);
        repeat (8) tick();
        out_ready = 1'b0;
        check("stream_no_dup_valid", 32'(out_valid), 32'd0);
        check("stream_end_count", 32'(count), 32'd0);

        // Reset during WR_HI of 0x1234
        in_valid = 1'b1;
        in_data  = 16'h1234;
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        check("rstmid_wrhi_i", 32'(sram_i), 32'h12);
        reset = 1'b1;
        #1;
        check("rstmid_count", 32'(count), 32'd0);
        check("rstmid_csb", 32'(sram_csb), 32'd1);
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("rstmid_idle_count", 32'(count), 32'd0);
        check("rstmid_idle_valid", 32'(out_valid), 32'd0);
        push(16'hBEEF);
        pop(16'hBEEF);
        repeat (6) tick();
        check("rstmid_after_valid", 32'(out_valid), 32'd0);
        check("rstmid_after_count", 32'(count), 32'd0);

`ifdef SRAM_SAMPLE_FIFO_HWM_EN
        // High-water mark: prime output register, then 5 in SRAM, drain 3, add 1
        push(16'h0101);
        repeat (6) tick();
        for (int i = 1; i <= 5; i++) push(16'(16'h0200 + i));
        repeat (4) tick();
        check("hwm_peak_count", 32'(count), 32'd5);
        check("hwm_peak", 32'(hwm), 32'd5);
        pop(16'h0101);
        pop(16'h0201);
        pop(16'h0202);
        push(16'h0206);
        repeat (6) tick();
        check("hwm_final_count", 32'(count), 32'd3);
        check("hwm_final", 32'(hwm), 32'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
